// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the RV32M multiply execution unit.
//   - FSM state encoding (IDLE / BUSY / REQ) as plain localparam constants
//   - RV32M funct3 codes for the multiply class
//   - opcode/funct7 constants used by dispatch steering
//   - mult_select(): picks the architectural result from the 64-bit product
package mult_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_REQ  = 2'd2;

  // Multiply-class funct3 codes; funct3[2]=1 is the divide class
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // RV32M encoding, consumed by dispatch steering
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Low word for MUL, high word for the MULH family, zero for divide-class
  // ops so they still broadcast and free their queue entry.
  function automatic logic [31:0] mult_select(input logic [2:0]  funct3,
                                              input logic [63:0] product);
    logic [31:0] r;
    r = '0;
    case (funct3)
      F3_MUL:                       r = product[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: r = product[63:32];
      default:                      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_core.sv
// mult_core: combinational RV32M multiply datapath.
//   op_a_i   [31:0] operand A (rs1)
//   op_b_i   [31:0] operand B (rs2)
//   funct3_i [2:0]  operation select
//   result_o [31:0] selected result word
// Operands are extended to 33 bits (sign or zero per funct3), so a single
// signed multiply covers all signedness combinations.
module mult_core
  import mult_pkg::*;
(
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic               a_signed;
  logic               b_signed;
  logic [32:0]        a_ext;
  logic [32:0]        b_ext;
  logic signed [63:0] a_wide;
  logic signed [63:0] b_wide;
  logic [63:0]        product;

  assign a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
  assign b_signed = (funct3_i == F3_MULH);

  assign a_ext = {a_signed & op_a_i[31], op_a_i};
  assign b_ext = {b_signed & op_b_i[31], op_b_i};

  // Only the low 64 bits of the 66-bit signed product are ever selected,
  // so the multiply is done at 64 bits on the sign-extended 33-bit values.
  assign a_wide  = {{31{a_ext[32]}}, a_ext};
  assign b_wide  = {{31{b_ext[32]}}, b_ext};
  assign product = a_wide * b_wide;

  assign result_o = mult_select(funct3_i, product);

endmodule

// File: rtl/mult_exec_unit.sv
// mult_exec_unit: multi-cycle RV32M multiply unit downstream of the issue queue.
//   clk, rst (synchronous, active-low)
//   issue_valid/issue_rs1_data/issue_rs2_data/issue_rd_token/issue_funct3 : issue side
//   ex_ready : idle, can accept this cycle
//   ex_done  : one-cycle pulse on the broadcast cycle
//   cdb_req/cdb_grant/cdb_valid/cdb_tag/cdb_data : CDB handshake; data and tag
//              are zero outside REQ so several units can be OR-merged.
// Optional build macro MULT_EARLY_OUT_EN: a zero operand skips straight to
// REQ (result 0), giving cdb_req in the cycle after accept.
module mult_exec_unit
  import mult_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [31:0]      issue_rs1_data,
  input  logic [31:0]      issue_rs2_data,
  input  logic [TAG_W:0]   issue_rd_token,
  input  logic [2:0]       issue_funct3,
  output logic             ex_ready,
  output logic             ex_done,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
);

  localparam int CNT_W = 5;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       a_q, b_q;
  logic [2:0]        f3_q;
  logic [TAG_W-1:0]  tag_q;
  logic              accept;
  logic              in_req;
  logic [31:0]       result;

  // Token bit TAG_W marks a real destination; invalid tokens are not accepted.
  assign accept = (state_q == S_IDLE) && issue_valid && issue_rd_token[TAG_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_REQ;
            cnt_d   = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
`ifdef MULT_EARLY_OUT_EN
          if ((issue_rs1_data == 32'h0) || (issue_rs2_data == 32'h0)) begin
            state_d = S_REQ;
            cnt_d   = '0;
          end
`endif
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (cdb_grant) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q   <= issue_rs1_data;
        b_q   <= issue_rs2_data;
        f3_q  <= issue_funct3;
        tag_q <= issue_rd_token[TAG_W-1:0];
      end
    end
  end

  // Operands stay latched until the next accept, so the result is stable
  // for the whole REQ interval without a separate result register.
  mult_core u_core (
    .op_a_i   (a_q),
    .op_b_i   (b_q),
    .funct3_i (f3_q),
    .result_o (result)
  );

  // Outputs are forced quiet while reset is low, even before the reset edge.
  assign in_req    = rst && (state_q == S_REQ);
  assign ex_ready  = rst && (state_q == S_IDLE);
  assign cdb_req   = in_req;
  assign cdb_valid = in_req && cdb_grant;
  assign ex_done   = in_req && cdb_grant;
  assign cdb_tag   = in_req ? tag_q  : '0;
  assign cdb_data  = in_req ? result : '0;

endmodule

// File: tb/tb_mult_exec_unit.sv
module tb_mult_exec_unit;
  import mult_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_rs1_data = '0;
  logic [31:0] issue_rs2_data = '0;
  logic [6:0]  issue_rd_token = '0;
  logic [2:0]  issue_funct3 = '0;
  logic        ex_ready, ex_done, cdb_req, cdb_valid;
  logic        cdb_grant = 1'b0;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_exec_unit #(.LATENCY(LAT), .TAG_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_rs1_data (issue_rs1_data),
    .issue_rs2_data (issue_rs2_data),
    .issue_rd_token (issue_rd_token),
    .issue_funct3   (issue_funct3),
    .ex_ready       (ex_ready),
    .ex_done        (ex_done),
    .cdb_req        (cdb_req),
    .cdb_grant      (cdb_grant),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [5:0]  tag;
    int          gdly;
    bit          spur;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (f3)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                              input logic [5:0] tag, input int gdly, input bit spur,
                              input logic [31:0] exp);
    vec_t v;
    v.a = a; v.b = b; v.f3 = f3; v.tag = tag; v.gdly = gdly; v.spur = spur; v.exp = exp;
    return v;
  endfunction

  function automatic logic [41:0] outs();
    return {ex_ready, cdb_req, cdb_valid, ex_done, cdb_tag, cdb_data};
  endfunction

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/req/val/done=%b tag=%h data=%h, need rdy/req/val/done=%b tag=%h data=%h",
               name, act[41:38], act[37:32], act[31:0], exp[41:38], exp[37:32], exp[31:0]);
    end
  endtask

  localparam logic [41:0] IDLE_OUT = {4'b1000, 6'h0, 32'h0};

  // One transaction; cycle 0 is the accept cycle, every cycle is compared
  // through the return to IDLE.
  task automatic run_op(input vec_t v, input string name);
    int          lexp, gcyc;
    logic [41:0] e;
    lexp = LAT;
`ifdef MULT_EARLY_OUT_EN
    if (v.a == 32'h0 || v.b == 32'h0) lexp = 1;
`endif
    gcyc = lexp + v.gdly;
    for (int c = 0; c <= gcyc + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        issue_valid = 1'b1; issue_rs1_data = v.a; issue_rs2_data = v.b;
        issue_funct3 = v.f3; issue_rd_token = {1'b1, v.tag};
      end else if (v.spur && c < lexp) begin
        issue_valid = 1'b1; issue_rs1_data = ~v.a; issue_rs2_data = v.b + 32'd1;
        issue_funct3 = 3'd0; issue_rd_token = {1'b1, ~v.tag};
      end else begin
        issue_valid = 1'b0;
      end
      cdb_grant = (v.gdly == 0) || (c >= gcyc);
      @(negedge clk);
      if (c == 0)          e = IDLE_OUT;
      else if (c < lexp)   e = '0;
      else if (c < gcyc)   e = {4'b0100, v.tag, v.exp};
      else if (c == gcyc)  e = {4'b0111, v.tag, v.exp};
      else                 e = IDLE_OUT;
      chk($sformatf("%s_c%0d", name, c), outs(), e);
    end
    $display("op %s a=%h b=%h f3=%0d tag=%h exp=%h", name, v.a, v.b, v.f3, v.tag, v.exp);
    cdb_grant = 1'b0;
  endtask

  initial begin
    // Directed table
    vecs.push_back(mk(32'd7,        32'hFFFFFFFD, F3_MUL,    6'h15, 0, 0, 32'hFFFFFFEB));
    vecs.push_back(mk(32'h80000000, 32'h80000000, F3_MULH,   6'h01, 0, 0, 32'h40000000));
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, F3_MULHU,  6'h02, 0, 0, 32'hFFFFFFFE));
    vecs.push_back(mk(32'hFFFFFFFF, 32'd2,        F3_MULHSU, 6'h03, 0, 0, 32'hFFFFFFFF));
    vecs.push_back(mk(32'h12345678, 32'd9,        F3_MUL,    6'h3C, 3, 0, 32'hA3D70A38));
    vecs.push_back(mk(32'h00010000, 32'h00010000, F3_MULHU,  6'h2A, 0, 1, 32'h00000001));
    vecs.push_back(mk(32'd5,        32'd6,        3'b100,    6'h11, 1, 0, 32'h0));
    vecs.push_back(mk(32'd0,        32'd5,        F3_MUL,    6'h07, 0, 0, 32'h0));
    vecs.push_back(mk(32'hDEADBEEF, 32'h1234,     3'b111,    6'h3F, 0, 0, 32'h0));
    vecs.push_back(mk(32'hFFFFFFFE, 32'hFFFFFFFD, F3_MULH,   6'h20, 2, 1, 32'h00000000));

    // Reset state
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold", outs(), '0);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("reset_release", outs(), IDLE_OUT);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Invalid token in IDLE must not start an operation
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_rs1_data = 32'd3; issue_rs2_data = 32'd3;
    issue_funct3 = F3_MUL; issue_rd_token = 7'h05;
    cdb_grant = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk($sformatf("badtok_c%0d", c), outs(), IDLE_OUT);
      @(posedge clk); #1; issue_valid = 1'b0;
    end
    cdb_grant = 1'b0;
    $display("op badtok ignored");

    // Reset while BUSY with counter at 2 drops the result
    issue_valid = 1'b1; issue_rs1_data = 32'd3; issue_rs2_data = 32'd4;
    issue_funct3 = F3_MUL; issue_rd_token = {1'b1, 6'h09};
    cdb_grant = 1'b1;
    @(negedge clk); chk("rstbusy_accept", outs(), IDLE_OUT);
    @(posedge clk); #1; issue_valid = 1'b0;
    @(negedge clk); chk("rstbusy_c1", outs(), '0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("rstbusy_inreset", outs(), '0);
    @(posedge clk); #1; rst = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk($sformatf("rstbusy_after%0d", c), outs(), IDLE_OUT);
      @(posedge clk); #1;
    end
    cdb_grant = 1'b0;
    $display("op reset-in-busy dropped");

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      vec_t v;
      v.a    = (i % 6 == 5) ? 32'h0 : $urandom;
      v.b    = (i % 4 == 3) ? 32'h80000000 : $urandom;
      v.f3   = 3'($urandom_range(0, 7));
      v.tag  = 6'($urandom_range(0, 63));
      v.gdly = $urandom_range(0, 3);
      v.spur = 1'($urandom_range(0, 1));
      v.exp  = ref_mul(v.a, v.b, v.f3);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_exec_unit.md
Name: mult_exec_unit

Overview:
- Multi-cycle RV32M multiply execution unit sitting directly downstream of the multiply issue queue.
- Accepts one issued instruction (operands, rd token, funct3) when idle.
- Computes MUL/MULH/MULHSU/MULHU over a fixed latency, then requests the CDB and holds the result until granted.
- Pulses ex_done back to the issue queue on the broadcast cycle so the queue frees its entry.

Parameters:
- LATENCY, 4, cycles from accept to first cdb_req assertion (legal range 1..16).
- TAG_W, 6, physical register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- issue_valid  in  1  issue queue presents a valid instruction.
- issue_rs1_data  in  32  operand A.
- issue_rs2_data  in  32  operand B.
- issue_rd_token  in  7  [6]=valid, [5:0]=destination tag.
- issue_funct3  in  3  operation select.
- ex_ready  out  1  unit idle, can accept this cycle.
- ex_done  out  1  one-cycle pulse, result broadcast this cycle.
- cdb_req  out  1  request CDB ownership.
- cdb_grant  in  1  arbiter grant.
- cdb_valid  out  1  result valid on CDB.
- cdb_tag  out  6  destination tag.
- cdb_data  out  32  result.

Behaviour:
- Reset: synchronous, active-low, checked only at posedge clk. While rst=0:
  - next state is IDLE; counter=0.
  - ex_done, cdb_req, cdb_valid = 0; cdb_tag=0, cdb_data=0.
  - ex_ready=0 during reset, 1 in the first cycle after rst returns to 1.
- FSM states: IDLE, BUSY, REQ.
- IDLE: ex_ready=1.
  - If issue_valid=1 and issue_rd_token[6]=1: latch operands, funct3 and tag[5:0].
  - If LATENCY=1, go to REQ; otherwise go to BUSY with counter=LATENCY-1.
  - issue_valid with token[6]=0 is ignored.
- BUSY: ex_ready=0; counter decrements each cycle; at counter==1, go to REQ. Accept at cycle 0 gives cdb_req first high in cycle LATENCY.
- REQ:
  - cdb_req=1; cdb_tag and cdb_data held stable from the first REQ cycle until the grant.
  - cdb_valid = ex_done = cdb_grant (combinational, same cycle).
  - On grant, return to IDLE next cycle. Without grant, remain in REQ indefinitely with outputs stable.
- Outside REQ: cdb_valid=0, cdb_req=0, cdb_tag=0, cdb_data=0 (zeroed so the unit can be OR-merged onto the CDB).
- Back-to-back: a new accept is possible only in IDLE. Minimum initiation interval is LATENCY+1 cycles with immediate grant.
- issue_valid asserted while not IDLE is ignored; the queue holds the instruction.
- Arithmetic: form 33-bit extended operands, then take a 66-bit signed product.
  - A is sign-extended for MULH/MULHSU, zero-extended otherwise.
  - B is sign-extended for MULH only.
  - funct3 000 (MUL): product[31:0].
  - funct3 001/010/011 (MULH/MULHSU/MULHU): product[63:32].
  - funct3 1xx (divide class, unsupported here): result 32'h0, still broadcast so the queue never deadlocks.
- cdb_grant outside REQ has no effect.
- Reset asserted in BUSY or REQ: the in-flight result is dropped with no broadcast and no ex_done.

Optional Feature:
- Macro: MULT_EARLY_OUT_EN.
- Defined: in IDLE, if the accepted rs1_data==0 or rs2_data==0, go directly to REQ with result 0. cdb_req is then high in cycle 1 regardless of LATENCY.
- Undefined: every operation takes the full LATENCY.

Decomposition:
- Package mult_pkg:
  - state enum (IDLE, BUSY, REQ).
  - funct3 constants (F3_MUL=3'b000, F3_MULH=3'b001, F3_MULHSU=3'b010, F3_MULHU=3'b011).
  - RV32M constants OPCODE_OP=7'b0110011, FUNCT7_MULDIV=7'b0000001 (used by dispatch steering).
  - result-select function.
- Sub-module mult_core: operand extension plus 33x33 signed multiply, result select by funct3. Pure datapath; the FSM and counter stay in mult_exec_unit.

Test Plan:
- MUL, rs1=7, rs2=32'hFFFFFFFD (-3), tag 0x15, grant tied high → cdb_valid in cycle 4, cdb_data=32'hFFFFFFEB, cdb_tag=0x15, ex_done same cycle.
- MULH, rs1=rs2=32'h80000000 → 32'h40000000. MULHU, rs1=rs2=32'hFFFFFFFF → 32'hFFFFFFFE. MULHSU, rs1=32'hFFFFFFFF, rs2=2 → 32'hFFFFFFFF.
- cdb_grant held low 3 cycles after cdb_req rises → cdb_req/tag/data stable, cdb_valid=ex_done=0; grant in 4th cycle → single ex_done pulse; ex_ready=1 next cycle.
- issue_valid pulsed during BUSY with a different tag → ignored; only the first tag is broadcast.
- rst=0 for one cycle while in BUSY (counter=2) → no cdb_req, no ex_done; ex_ready=1 the cycle after rst=1.
- MULT_EARLY_OUT_EN defined, MUL rs1=0, rs2=5 → cdb_req in cycle 1, data 0. Undefined → cdb_req in cycle 4.
